// File: rtl/seq_pkg.sv
// Shared constants for the multi-cycle sequencer: state encoding, instruction
// classes and default datapath widths.
package seq_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  localparam logic [1:0] CL_ALU = 2'b00;
  localparam logic [1:0] CL_MEM = 2'b01;
  localparam logic [1:0] CL_BR  = 2'b10;
  localparam logic [1:0] CL_SYS = 2'b11;

endpackage

// File: rtl/pc_unit.sv
// Program counter: absolute load has priority over increment; the increment
// wraps naturally at 2^ADDR_W.
module pc_unit
  import seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 16-bit core: fetch, decode, execute, memory,
// writeback, with PC ownership, memory handshakes and a retired counter.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  output logic              ir_load,
  input  logic [DATA_W-1:0] instr,
  input  logic              bool_flag,
  output logic              dmem_rd_req,
  output logic              dmem_wr_req,
  input  logic              dmem_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire, pc_inc, pc_load;
  logic [1:0]       cls;
  logic             is_store, is_halt, br_taken;

  assign cls      = instr[15:14];
  assign is_store = instr[13];
  assign is_halt  = (instr[13:0] == 14'd0);
  assign br_taken = !instr[13] || bool_flag;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        case (cls)
          CL_ALU: state_d = ST_WB;
          CL_MEM: state_d = ST_MEM;
          CL_BR: begin
            pc_load = br_taken;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          default: begin
            retire  = 1'b1;
            state_d = is_halt ? ST_HALT : ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) begin
          retire  = is_store;
          state_d = is_store ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT:   if (!run) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Counter saturates at all-ones rather than wrapping.
  always_comb begin
    retired_d = retired_q;
    if (retire && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  pc_unit #(.ADDR_W(ADDR_W)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (pc_inc),
    .load_i     (pc_load),
    .load_val_i (instr[ADDR_W-1:0]),
    .pc_o       (pc)
  );

  // Handshake: a request is a Moore decode of state and stays high until the
  // edge that samples its ready; ready with no request active is ignored.
  assign imem_req    = (state_q == ST_FETCH);
  assign ir_load     = imem_req && imem_ready;
  assign dmem_rd_req = (state_q == ST_MEM) && !is_store;
  assign dmem_wr_req = (state_q == ST_MEM) && is_store;
  assign rf_we       = (state_q == ST_WB);
  assign halted      = (state_q == ST_HALT);
  assign imem_addr   = pc;
  assign state       = state_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: memory responders with programmable
// wait states, a per-instruction cycle-schedule model, and literal pins.
module tb_multicycle_sequencer;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic run = 1'b0;
  logic imem_ready = 1'b0;
  logic dmem_ready = 1'b0;
  logic bool_flag = 1'b0;
  logic [DW-1:0] instr = '0;
  logic imem_req, ir_load, dmem_rd_req, dmem_wr_req, rf_we, halted;
  logic [AW-1:0] imem_addr, pc;
  logic [2:0] state;
  logic [CW-1:0] retired;

  logic [DW-1:0] mem [64];
  int iw_cfg, dw_cfg, icnt, dcnt;
  bit noise;

  // record: {state[30:28], pc[27:22], retired[21:6], imem_req, ir_load, rd, wr, rf_we, halted}
  logic [30:0] exp_q[$];
  logic [30:0] obs [512];
  logic [AW-1:0] obs_addr [512];
  int cyc;
  logic [AW-1:0] m_pc;
  logic [CW-1:0] m_ret;
  int errors = 0;
  int checks = 0;

  multicycle_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .ir_load(ir_load), .instr(instr), .bool_flag(bool_flag),
    .dmem_rd_req(dmem_rd_req), .dmem_wr_req(dmem_wr_req), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc(pc), .state(state), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  // Memory responders: ready after the configured number of wait cycles;
  // the instruction register is modelled as loading on the completing cycle.
  always @(negedge clk) begin
    if (imem_req) begin
      if (icnt == iw_cfg) begin
        imem_ready = 1'b1;
        instr = mem[imem_addr];
        icnt = 0;
      end else begin
        imem_ready = 1'b0;
        icnt++;
      end
    end else begin
      imem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      icnt = 0;
    end
    if (dmem_rd_req || dmem_wr_req) begin
      if (dcnt == dw_cfg) begin
        dmem_ready = 1'b1;
        dcnt = 0;
      end else begin
        dmem_ready = 1'b0;
        dcnt++;
      end
    end else begin
      dmem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      dcnt = 0;
    end
  end

  function automatic void push(logic [2:0] st, logic ireq, logic ild, logic rd,
                               logic wr, logic we, logic hl);
    exp_q.push_back({st, m_pc, m_ret, ireq, ild, rd, wr, we, hl});
  endfunction

  function automatic void bump();
    if (m_ret != {CW{1'b1}}) m_ret = m_ret + 1'b1;
  endfunction

  // Expected cycle schedule of the instruction at m_pc.
  task automatic plan_instr();
    logic [DW-1:0] w;
    w = mem[m_pc];
    for (int i = 0; i <= iw_cfg; i++)
      push(S_FETCH, 1'b1, (i == iw_cfg), 1'b0, 1'b0, 1'b0, 1'b0);
    m_pc = m_pc + 1'b1;
    push(S_DEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    case (w[15:14])
      2'b00: begin
        push(S_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bump();
      end
      2'b01: begin
        for (int i = 0; i <= dw_cfg; i++)
          push(S_MEM, 1'b0, 1'b0, !w[13], w[13], 1'b0, 1'b0);
        if (!w[13]) push(S_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bump();
      end
      2'b10: begin
        if (!w[13] || bool_flag) m_pc = w[5:0];
        bump();
      end
      default: bump();
    endcase
  endtask

  task automatic plan_halt(int n);
    for (int i = 0; i < n; i++) push(S_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic plan_idle(int n);
    for (int i = 0; i < n; i++) push(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_cycle();
    logic [30:0] e, a;
    logic [AW-1:0] ea;
    @(negedge clk);
    #2;
    e = exp_q.pop_front();
    a = {state, pc, retired, imem_req, ir_load, dmem_rd_req, dmem_wr_req, rf_we, halted};
    ea = e[27:22];
    if (cyc < 512) begin
      obs[cyc] = a;
      obs_addr[cyc] = imem_addr;
    end
    checks++;
    if (a !== e || imem_addr !== ea) begin
      errors++;
      $display("FAIL cycle%0d: got state=%0d pc=%0d addr=%0d ret=%0d flags=%06b, want state=%0d pc=%0d ret=%0d flags=%06b",
               cyc, a[30:28], a[27:22], imem_addr, a[21:6], a[5:0],
               e[30:28], e[27:22], e[21:6], e[5:0]);
    end
    cyc++;
  endtask

  task automatic run_checks(int n);
    for (int i = 0; i < n; i++) if (exp_q.size() > 0) check_cycle();
  endtask

  task automatic run_all();
    run_checks(exp_q.size());
  endtask

  task automatic pin(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  function automatic int count_bit(int pos);
    int n = 0;
    for (int i = 0; i < cyc && i < 512; i++) if (obs[i][pos]) n++;
    return n;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'hC000;
  endtask

  // Reset (checking the async reset values), configure, then release.
  task automatic start(int iw, int dw, bit nz, logic bf);
    logic [30:0] a;
    rst_n = 1'b0;
    run = 1'b1;
    #1;
    a = {state, pc, retired, imem_req, ir_load, dmem_rd_req, dmem_wr_req, rf_we, halted};
    pin("reset_state", int'(a), 0);
    iw_cfg = iw;
    dw_cfg = dw;
    noise = nz;
    bool_flag = bf;
    m_pc = '0;
    m_ret = '0;
    cyc = 0;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    plan_idle(1);
  endtask

  initial begin
    #3;
    // ALU then HALT; hold in HALT with run=1, drop run to IDLE
    clear_mem();
    mem[0] = 16'h0123;
    start(0, 0, 1'b0, 1'b0);
    plan_instr();
    plan_instr();
    plan_halt(3);
    run_all();
    run = 1'b0;
    plan_idle(2);
    run_all();
    pin("alu_imem_req_c1", int'(obs[1][5]), 1);
    pin("alu_rf_we_c4", int'(obs[4][1]), 1);
    pin("alu_refetch_state_c5", int'(obs[5][30:28]), 1);
    pin("alu_refetch_pc_c5", int'(obs[5][27:22]), 1);
    pin("alu_refetch_ret_c5", int'(obs[5][21:6]), 1);
    pin("halt_halted_c8", int'(obs[8][0]), 1);
    pin("halt_idle_pc_c12", int'(obs[12][27:22]), 2);
    pin("halt_idle_state_c12", int'(obs[12][30:28]), 0);

    // Load with 3 wait cycles on the data memory
    clear_mem();
    mem[0] = 16'h4005;
    start(1, 3, 1'b0, 1'b0);
    plan_instr();
    plan_instr();
    plan_halt(2);
    run_all();
    pin("load_rd_cycles", count_bit(3), 4);
    pin("load_rf_we_pulses", count_bit(1), 1);
    pin("load_wr_cycles", count_bit(2), 0);

    // Store then ALU, with ready noise outside requests
    clear_mem();
    mem[0] = 16'h6007;
    mem[1] = 16'h0000;
    start(0, 2, 1'b1, 1'b0);
    plan_instr();
    plan_instr();
    plan_instr();
    plan_halt(2);
    run_all();
    pin("store_wr_cycles", count_bit(2), 3);
    pin("store_rf_we_pulses", count_bit(1), 1);

    // Conditional branch, taken
    clear_mem();
    mem[0] = 16'hA02A;
    start(0, 0, 1'b0, 1'b1);
    plan_instr();
    plan_instr();
    plan_halt(1);
    run_all();
    pin("br_taken_addr_c4", int'(obs_addr[4]), 42);

    // Conditional branch, not taken
    clear_mem();
    mem[0] = 16'hA02A;
    start(0, 0, 1'b0, 1'b0);
    plan_instr();
    plan_instr();
    plan_halt(1);
    run_all();
    pin("br_not_taken_addr_c4", int'(obs_addr[4]), 1);
    pin("br_not_taken_rf_we", count_bit(1), 0);

    // PC wrap: jump to 63, NOP there, next fetch at 0
    clear_mem();
    mem[0] = 16'h803F;
    mem[63] = 16'hC001;
    start(0, 0, 1'b0, 1'b0);
    plan_instr();
    run_all();
    mem[0] = 16'hC000;
    plan_instr();
    plan_instr();
    plan_halt(1);
    run_all();
    pin("wrap_addr_c4", int'(obs_addr[4]), 63);
    pin("wrap_addr_c7", int'(obs_addr[7]), 0);

    // Reset pulsed in the middle of a load's MEM wait
    clear_mem();
    mem[0] = 16'h0123;
    mem[1] = 16'h4005;
    start(0, 5, 1'b0, 1'b0);
    plan_instr();
    plan_instr();
    run_checks(10);
    rst_n = 1'b0;
    #1;
    pin("rst_mid_mem_rd_req", int'(dmem_rd_req), 0);
    pin("rst_mid_mem_state", int'(state), 0);
    pin("rst_mid_mem_pc", int'(pc), 0);
    pin("rst_mid_mem_retired", int'(retired), 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
